// File: rtl/game_pkg.sv
// Shared encodings for the board-game datapath: the cell value encoding,
// the derived cell width and the commit controller state type.
package game_pkg;

    localparam int CELL_EMPTY = 0;

    // A cell holds 0 for empty or p+1 for player p, so it needs room for PLAYERS+1 values.
    function automatic int cell_w(input int players);
        return $clog2(players + 1);
    endfunction

    typedef enum logic {
        IDLE,
        CHECK
    } mc_state_t;

endpackage

// File: rtl/cell_onehot_decoder.sv
// Decodes a one-hot switch selection into a cell index, flagging whether the
// pattern is exactly one-hot and whether the selected bit addresses a real cell.
module cell_onehot_decoder
    import game_pkg::*;
#(
    parameter  int SW_W  = 10,
    parameter  int CELLS = 9,
    localparam int IDX_W = (SW_W > 1) ? $clog2(SW_W) : 1
) (
    input  logic [SW_W-1:0]  sw,
    output logic [IDX_W-1:0] idx,
    output logic             onehot,
    output logic             in_range
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < SW_W; i++) begin
            if (sw[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only when at most one bit was set.
    assign onehot   = (sw != '0) && ((sw & (sw - SW_W'(1))) == '0);
    assign in_range = onehot && (int'(idx) < CELLS);

endmodule

// File: rtl/move_commit_ctrl.sv
// Captures a one-hot cell selection on a submit-key rise, validates it against
// the stored board and commits legal moves, rotating the turn among the players.
module move_commit_ctrl
    import game_pkg::*;
#(
    parameter  int CELLS   = 9,
    parameter  int SW_W    = 10,
    parameter  int PLAYERS = 2,
    parameter  int CW      = cell_w(PLAYERS),
    localparam int PW      = $clog2(PLAYERS),
    localparam int MI_W    = (CELLS > 1) ? $clog2(CELLS) : 1,
    localparam int MC_W    = $clog2(CELLS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  submit,
    input  logic [SW_W-1:0]       sw,
    input  logic                  new_game,
    output logic [CELLS*CW-1:0]   board,
    output logic [PW-1:0]         player,
    output logic                  move_ok,
    output logic                  move_err,
    output logic [MI_W-1:0]       move_idx,
    output logic [MC_W-1:0]       move_count,
    output logic                  full,
    output logic                  busy
);

    localparam int IDX_W = (SW_W > 1) ? $clog2(SW_W) : 1;

    mc_state_t             state_q;
    logic                  submit_q;
    logic [SW_W-1:0]       sw_q;
    logic [CELLS*CW-1:0]   board_q;
    logic [CELLS*CW-1:0]   board_d;
    logic [PW-1:0]         player_q;
    logic [PW-1:0]         player_d;
    logic                  move_ok_q;
    logic                  move_err_q;
    logic [MI_W-1:0]       move_idx_q;
    logic [MC_W-1:0]       move_count_q;

    logic                  sub_rise;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_onehot;
    logic                  dec_in_range;
    logic [CW-1:0]         cell_val;
    logic                  legal;

    cell_onehot_decoder #(
        .SW_W  (SW_W),
        .CELLS (CELLS)
    ) u_decoder (
        .sw       (sw_q),
        .idx      (dec_idx),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    assign sub_rise = submit & ~submit_q;

    // Looping over real cells keeps an out-of-range index from reading past the board.
    always_comb begin
        cell_val = '0;
        board_d  = board_q;
        for (int c = 0; c < CELLS; c++) begin
            if (dec_idx == IDX_W'(c)) begin
                cell_val                 = board_q[c*CW +: CW];
                board_d[c*CW +: CW]      = CW'(player_q) + CW'(1);
            end
        end
    end

    always_comb begin
        player_d = player_q + PW'(1);
        if (player_q == PW'(PLAYERS - 1)) begin
            player_d = '0;
        end
    end

    assign legal = dec_onehot && dec_in_range && (cell_val == CW'(CELL_EMPTY)) && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            submit_q     <= 1'b1;
            sw_q         <= '0;
            board_q      <= '0;
            player_q     <= '0;
            move_ok_q    <= 1'b0;
            move_err_q   <= 1'b0;
            move_idx_q   <= '0;
            move_count_q <= '0;
        end else begin
            submit_q   <= submit;
            move_ok_q  <= 1'b0;
            move_err_q <= 1'b0;
            if (new_game) begin
                state_q      <= IDLE;
                board_q      <= '0;
                player_q     <= '0;
                move_count_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sub_rise && enable) begin
                            sw_q    <= sw;
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        state_q <= IDLE;
                        if (legal) begin
                            board_q      <= board_d;
                            player_q     <= player_d;
                            move_idx_q   <= dec_idx[MI_W-1:0];
                            move_count_q <= move_count_q + MC_W'(1);
                            move_ok_q    <= 1'b1;
                        end else begin
                            move_err_q   <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign board      = board_q;
    assign player     = player_q;
    assign move_ok    = move_ok_q;
    assign move_err   = move_err_q;
    assign move_idx   = move_idx_q;
    assign move_count = move_count_q;
    assign full       = (move_count_q == MC_W'(CELLS));
    assign busy       = (state_q != IDLE);

endmodule
